// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit returning {HI,LO} with a completion pulse.
// Optional MD_FAST_MUL_EN: single registered multiply instead of 32-step shift-add.
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mult_en,
   input  logic              div_en,
   input  logic              is_signed,
   input  logic [XLEN-1:0]   src1,
   input  logic [XLEN-1:0]   src2,
   input  logic              flush,
   output logic              busy,
   output logic              md_complete,
   output logic [2*XLEN-1:0] md_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_signed;
   logic              r_sa;
   logic              r_sb;
   logic              r_dz;
   logic              r_div;
   logic [XLEN-1:0]   r_op;
   logic [2*XLEN-1:0] r_acc;
   logic              r_complete;
   logic [2*XLEN-1:0] r_result;

   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic              w_start_mul;
   logic              w_start_div;
   logic              w_last;
   logic [XLEN:0]     w_madd;
   logic [2*XLEN-1:0] w_mul_nxt;
   logic [XLEN:0]     w_shift;
   logic [XLEN+1:0]   w_sub;
   logic [2*XLEN-1:0] w_div_nxt;
   logic [2*XLEN-1:0] w_fix;
   logic [XLEN-1:0]   w_q;
   logic [XLEN-1:0]   w_r;

   assign w_abs1 = (is_signed && src1[XLEN-1]) ? (~src1 + 1'b1) : src1;
   assign w_abs2 = (is_signed && src2[XLEN-1]) ? (~src2 + 1'b1) : src2;

   assign w_start_mul = (r_state == S_IDLE) && !flush && mult_en;
   assign w_start_div = (r_state == S_IDLE) && !flush && !mult_en && div_en;
   assign w_last      = (r_cnt == {CNT_W{1'b1}});

   // Shift-add: upper half accumulates, multiplier bits retire from the bottom
   assign w_madd    = {1'b0, r_acc[2*XLEN-1:XLEN]}
                    + (r_acc[0] ? {1'b0, r_op} : {(XLEN+1){1'b0}});
   assign w_mul_nxt = {w_madd, r_acc[XLEN-1:1]};

   // Restoring divide: {rem, quo} shifts left, quotient bit enters at bit 0
   assign w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_sub     = {1'b0, w_shift} - {2'b00, r_op};
   assign w_div_nxt = w_sub[XLEN+1]
                    ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                    : {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

`ifdef MD_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fprod;
   assign w_fprod = {{XLEN{1'b0}}, r_op} * {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
`endif

   always_comb begin
      w_q   = r_acc[XLEN-1:0];
      w_r   = r_acc[2*XLEN-1:XLEN];
      w_fix = r_acc;
      if (r_div) begin
         if (r_dz)
            w_q = {XLEN{1'b1}};
         else if (r_signed && (r_sa ^ r_sb))
            w_q = ~r_acc[XLEN-1:0] + 1'b1;
         if (r_signed && r_sa)
            w_r = ~r_acc[2*XLEN-1:XLEN] + 1'b1;
         w_fix = {w_r, w_q};
      end else if (r_signed && (r_sa ^ r_sb)) begin
         w_fix = ~r_acc + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_signed   <= 1'b0;
         r_sa       <= 1'b0;
         r_sb       <= 1'b0;
         r_dz       <= 1'b0;
         r_div      <= 1'b0;
         r_op       <= '0;
         r_acc      <= '0;
         r_complete <= 1'b0;
         r_result   <= '0;
      end else begin
         r_complete <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_mul || w_start_div) begin
                  r_state  <= w_start_mul ? S_MUL : S_DIV;
                  r_cnt    <= '0;
                  r_signed <= is_signed;
                  r_sa     <= is_signed & src1[XLEN-1];
                  r_sb     <= is_signed & src2[XLEN-1];
                  r_dz     <= (src2 == '0);
                  r_div    <= w_start_div;
                  r_op     <= w_start_mul ? w_abs1 : w_abs2;
                  r_acc    <= {{XLEN{1'b0}}, (w_start_mul ? w_abs2 : w_abs1)};
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
`ifdef MD_FAST_MUL_EN
                  r_acc   <= w_fprod;
                  r_state <= S_FIX;
`else
                  r_acc <= w_mul_nxt;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last)
                     r_state <= S_FIX;
`endif
               end
            end
            S_DIV: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_acc <= w_div_nxt;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last)
                     r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               if (!flush) begin
                  r_result   <= w_fix;
                  r_complete <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign md_complete = r_complete;
   assign md_result   = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: result table, latency, busy,
// flush, back-to-back start, request priority and mid-operation reset.
module tb_mul_div_unit;

   localparam int MUL_LAT =
`ifdef MD_FAST_MUL_EN
      2;
`else
      33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk;
   logic        resetn;
   logic        mult_en;
   logic        div_en;
   logic        is_signed;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        busy;
   logic        md_complete;
   logic [63:0] md_result;

   int n_cmp;
   int n_bad;

   typedef struct packed {
      logic        mul;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t tv [11];

   mul_div_unit dut (
      .clk(clk),
      .resetn(resetn),
      .mult_en(mult_en),
      .div_en(div_en),
      .is_signed(is_signed),
      .src1(src1),
      .src2(src2),
      .flush(flush),
      .busy(busy),
      .md_complete(md_complete),
      .md_result(md_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
      mult_en   = m;
      div_en    = d;
      is_signed = s;
      src1      = a;
      src2      = b;
   endtask

   // Called right after the start edge; returns at the negedge where
   // md_complete is seen (or when the cycle budget runs out).
   task automatic wait_done(input string nm, input int exp_lat,
                            input logic [63:0] exp_res);
      int lat;
      int nbusy;
      logic ok;
      lat   = 0;
      nbusy = 0;
      ok    = 1'b0;
      @(negedge clk);
      mult_en = 1'b0;
      div_en  = 1'b0;
      while (lat < 60) begin
         if (md_complete) begin
            ok = 1'b1;
            break;
         end
         if (!busy) nbusy++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({nm, " done"}, 64'(ok), 64'd1);
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, " busy_gaps"}, 64'(nbusy), 64'd0);
      chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
      chk({nm, " result"}, md_result, exp_res);
   endtask

   task automatic watch_idle(input string nm, input int cycles,
                             input logic [63:0] hold);
      int ncomp;
      int nbusy;
      ncomp = 0;
      nbusy = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (md_complete) ncomp++;
         if (busy) nbusy++;
      end
      chk({nm, " no_complete"}, 64'(ncomp), 64'd0);
      chk({nm, " stays_idle"}, 64'(nbusy), 64'd0);
      chk({nm, " result_held"}, md_result, hold);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      resetn = 1'b0;
      flush  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      tv[0]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      tv[1]  = '{1'b1, 1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
      tv[2]  = '{1'b1, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
      tv[3]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780};
      tv[4]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
      tv[5]  = '{1'b0, 1'b0, 32'h00000064, 32'h00000007, 64'h00000002_0000000E};
      tv[6]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
      tv[7]  = '{1'b0, 1'b0, 32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF};
      tv[8]  = '{1'b0, 1'b1, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFF0_FFFFFFFF};
      tv[9]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      tv[10] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};

      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset complete", 64'(md_complete), 64'd0);
      chk("reset result", md_result, 64'd0);
      resetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(tv[i].mul, !tv[i].mul, tv[i].sgn, tv[i].a, tv[i].b);
         @(posedge clk);
         wait_done($sformatf("vec%0d", i),
                   tv[i].mul ? MUL_LAT : DIV_LAT, tv[i].exp);
      end

      // New request presented in the same cycle as md_complete
      drive(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010);
      @(posedge clk);
      wait_done("chain", DIV_LAT, 64'h0000000F_0FFFFFFF);

      // Flush at iteration 10 together with an ignored new request
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'd55, 32'd5);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("flush busy_next", 64'(busy), 64'd0);
      watch_idle("flush", 40, 64'h0000000F_0FFFFFFF);

      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
      @(posedge clk);
      wait_done("post_flush", MUL_LAT, 64'h00000000_0000000C);

      // Flush while idle blocks the start on that edge
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'd9, 32'd9);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      watch_idle("idle_flush", 40, 64'h00000000_0000000C);

      // Multiply wins when both requests are raised
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'd6, 32'd3);
      @(posedge clk);
      wait_done("both_req", MUL_LAT, 64'h00000000_00000012);

      // Asynchronous reset at iteration 5 of a divide
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst complete", 64'(md_complete), 64'd0);
      chk("midrst result", md_result, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      watch_idle("after_rst", 45, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
